// File: rtl/cp0_unit_if.sv
// Controller <-> CP0 bus: MTC0/MFC0 access, exception strobes,
// device interrupt lines, and IntReq/EPC back to the controller.
interface cp0_unit_if;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic [31:0] PC;
  logic [5:0]  HWInt;
  logic        We;
  logic        EPCWr;
  logic        EXLSet;
  logic        EXLClr;
  logic        IntReq;
  logic [31:0] EPC;
  logic [31:0] DOut;

  modport master (
    output A1, A2, DIn, PC, HWInt,
    output We, EPCWr, EXLSet, EXLClr,
    input  IntReq, EPC, DOut
  );

  modport slave (
    input  A1, A2, DIn, PC, HWInt,
    input  We, EPCWr, EXLSet, EXLClr,
    output IntReq, EPC, DOut
  );
endinterface

// File: rtl/cp0_unit.sv
// Coprocessor 0: SR, Cause, EPC, PRId, Count/Compare
// and the interrupt request sampled by the controller.
module cp0_unit (
  input logic       clk,
  input logic       reset,
  cp0_unit_if.slave bus
);
  localparam logic [31:0] PRID = 32'h0000_4D50;

  localparam logic [4:0] A_COUNT = 5'd9;
  localparam logic [4:0] A_CMP   = 5'd11;
  localparam logic [4:0] A_SR    = 5'd12;
  localparam logic [4:0] A_CAUSE = 5'd13;
  localparam logic [4:0] A_EPC   = 5'd14;
  localparam logic [4:0] A_PRID  = 5'd15;

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic [5:0]  ip;
  logic        ti;
  logic [31:0] epc;
  logic [31:0] count;
  logic [31:0] compare;

  logic        wr_sr;
  logic        wr_epc;
  logic        wr_count;
  logic        wr_cmp;
  logic [31:0] cnt_nxt;
  logic [5:0]  ip_eff;
  logic [31:0] sr_rd;
  logic [31:0] cause_rd;
  logic [31:0] dout;

  assign wr_sr    = bus.We && (bus.A2 == A_SR);
  assign wr_epc   = bus.We && (bus.A2 == A_EPC);
  assign wr_count = bus.We && (bus.A2 == A_COUNT);
  assign wr_cmp   = bus.We && (bus.A2 == A_CMP);

  assign cnt_nxt = wr_count ? bus.DIn
                            : count + 32'd1;

  // Timer pending folds into the top IP bit.
  assign ip_eff = {ip[5] | ti, ip[4:0]};

  assign sr_rd    = {16'b0, im, 8'b0, exl, ie};
  assign cause_rd = {16'b0, ip_eff, 10'b0};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im  <= '0;
      exl <= 1'b0;
      ie  <= 1'b0;
    end else begin
      if (wr_sr) begin
        im <= bus.DIn[15:10];
        ie <= bus.DIn[0];
      end
      if (bus.EXLSet)
        exl <= 1'b1;
      else if (bus.EXLClr)
        exl <= 1'b0;
      else if (wr_sr)
        exl <= bus.DIn[1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ip <= '0;
    end else begin
      ip <= bus.HWInt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      epc <= '0;
    end else if (bus.EPCWr) begin
      epc <= bus.PC & ~32'd3;
    end else if (wr_epc) begin
      epc <= bus.DIn & ~32'd3;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      compare <= 32'hFFFF_FFFF;
      ti      <= 1'b0;
    end else begin
      count <= cnt_nxt;
      if (wr_cmp)
        compare <= bus.DIn;
      // A Compare write wins over a same-cycle match.
      if (wr_cmp)
        ti <= 1'b0;
      else if (cnt_nxt == compare)
        ti <= 1'b1;
    end
  end

  always_comb begin
    dout = '0;
    unique case (1'b1)
      (bus.A1 == A_COUNT): dout = count;
      (bus.A1 == A_CMP):   dout = compare;
      (bus.A1 == A_SR):    dout = sr_rd;
      (bus.A1 == A_CAUSE): dout = cause_rd;
      (bus.A1 == A_EPC):   dout = epc;
      (bus.A1 == A_PRID):  dout = PRID;
      default:             dout = '0;
    endcase
  end

  assign bus.DOut   = dout;
  assign bus.EPC    = epc;
  assign bus.IntReq = (|(ip_eff & im)) & ie & ~exl;
endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit: reset, interrupts, masking,
// timer, same-cycle collisions, illegal access and wrap.
module tb_cp0_unit;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  cp0_unit_if bus ();

  cp0_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic mtc0(input logic [4:0] a,
                      input logic [31:0] d);
    bus.A2  = a;
    bus.DIn = d;
    bus.We  = 1'b1;
    @(negedge clk);
    bus.We  = 1'b0;
    #1;
  endtask

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a);
    bus.A1 = a;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #2;
    rd(5'd12);
    total++;
    if (bus.DOut !== 32'h0) begin
      bad++;
      $display("FAIL reset_sr got=%h exp=%h", bus.DOut, 32'h0);
    end
    rd(5'd15);
    total++;
    if (bus.DOut !== 32'h0000_4D50) begin
      bad++;
      $display("FAIL reset_prid got=%h exp=%h", bus.DOut, 32'h0000_4D50);
    end
    total++;
    if (bus.EPC !== 32'h0 || bus.IntReq !== 1'b0) begin
      bad++;
      $display("FAIL reset_epc_irq got=%h/%b exp=0/0", bus.EPC, bus.IntReq);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    rd(5'd9);
    total++;
    if (bus.DOut !== 32'd3) begin
      bad++;
      $display("FAIL reset_count got=%0d exp=3", bus.DOut);
    end
  endtask

  task automatic test_device_int;
    mtc0(5'd12, 32'h0000_0401);
    bus.HWInt = 6'b000001;
    #1;
    total++;
    if (bus.IntReq !== 1'b0) begin
      bad++;
      $display("FAIL dev_latency got=%b exp=0", bus.IntReq);
    end
    step();
    total++;
    if (bus.IntReq !== 1'b1) begin
      bad++;
      $display("FAIL dev_irq got=%b exp=1", bus.IntReq);
    end
    bus.PC = 32'h0000_3008;
    bus.EPCWr = 1'b1;
    bus.EXLSet = 1'b1;
    step();
    bus.EPCWr = 1'b0;
    bus.EXLSet = 1'b0;
    rd(5'd12);
    total++;
    if (bus.EPC !== 32'h0000_3008) begin
      bad++;
      $display("FAIL dev_epc got=%h exp=%h", bus.EPC, 32'h0000_3008);
    end
    total++;
    if (bus.DOut !== 32'h0000_0403) begin
      bad++;
      $display("FAIL dev_sr got=%h exp=%h", bus.DOut, 32'h0000_0403);
    end
    total++;
    if (bus.IntReq !== 1'b0) begin
      bad++;
      $display("FAIL dev_exl_mask got=%b exp=0", bus.IntReq);
    end
    bus.EXLClr = 1'b1;
    step();
    bus.EXLClr = 1'b0;
    total++;
    if (bus.IntReq !== 1'b1) begin
      bad++;
      $display("FAIL dev_eret got=%b exp=1", bus.IntReq);
    end
    bus.HWInt = 6'b0;
    step();
    total++;
    if (bus.IntReq !== 1'b0) begin
      bad++;
      $display("FAIL dev_deassert got=%b exp=0", bus.IntReq);
    end
  endtask

  task automatic test_masking;
    mtc0(5'd12, 32'h0000_0001);
    bus.HWInt = 6'b111111;
    step();
    rd(5'd13);
    total++;
    if (bus.IntReq !== 1'b0) begin
      bad++;
      $display("FAIL mask_irq got=%b exp=0", bus.IntReq);
    end
    total++;
    if (bus.DOut !== 32'h0000_FC00) begin
      bad++;
      $display("FAIL mask_cause got=%h exp=%h", bus.DOut, 32'h0000_FC00);
    end
    bus.HWInt = 6'b0;
    step();
  endtask

  task automatic test_timer;
    logic [31:0] exp_cnt;
    logic        exp_irq;
    mtc0(5'd12, 32'h0000_8001);
    mtc0(5'd9, 32'd0);
    mtc0(5'd11, 32'd10);
    rd(5'd9);
    for (int k = 0; k < 13; k++) begin
      exp_cnt = 32'd1 + 32'(k);
      exp_irq = (exp_cnt >= 32'd10);
      total++;
      if (bus.DOut !== exp_cnt || bus.IntReq !== exp_irq) begin
        bad++;
        $display("FAIL timer_k%0d got=%0d/%b exp=%0d/%b",
                 k, bus.DOut, bus.IntReq, exp_cnt, exp_irq);
      end
      step();
    end
    mtc0(5'd11, 32'd100);
    total++;
    if (bus.IntReq !== 1'b0) begin
      bad++;
      $display("FAIL timer_clear got=%b exp=0", bus.IntReq);
    end
    mtc0(5'd11, 32'hFFFF_FFFF);
  endtask

  task automatic test_collisions;
    bus.A2 = 5'd14;
    bus.DIn = 32'h0000_1234;
    bus.We = 1'b1;
    bus.PC = 32'h0000_3000;
    bus.EPCWr = 1'b1;
    step();
    bus.We = 1'b0;
    bus.EPCWr = 1'b0;
    total++;
    if (bus.EPC !== 32'h0000_3000) begin
      bad++;
      $display("FAIL col_epc got=%h exp=%h", bus.EPC, 32'h0000_3000);
    end
    mtc0(5'd12, 32'h0);
    bus.EXLSet = 1'b1;
    bus.EXLClr = 1'b1;
    step();
    bus.EXLSet = 1'b0;
    bus.EXLClr = 1'b0;
    rd(5'd12);
    total++;
    if (bus.DOut !== 32'h0000_0002) begin
      bad++;
      $display("FAIL col_exl_set got=%h exp=%h", bus.DOut, 32'h2);
    end
    bus.EXLClr = 1'b1;
    bus.A2 = 5'd12;
    bus.DIn = 32'h0000_0403;
    bus.We = 1'b1;
    step();
    bus.EXLClr = 1'b0;
    bus.We = 1'b0;
    rd(5'd12);
    total++;
    if (bus.DOut !== 32'h0000_0401) begin
      bad++;
      $display("FAIL col_exl_clr got=%h exp=%h", bus.DOut, 32'h401);
    end
  endtask

  task automatic test_illegal;
    mtc0(5'd13, 32'hFFFF_FFFF);
    rd(5'd13);
    total++;
    if (bus.DOut !== 32'h0) begin
      bad++;
      $display("FAIL ill_cause got=%h exp=0", bus.DOut);
    end
    mtc0(5'd15, 32'h0);
    rd(5'd15);
    total++;
    if (bus.DOut !== 32'h0000_4D50) begin
      bad++;
      $display("FAIL ill_prid got=%h exp=%h", bus.DOut, 32'h4D50);
    end
    mtc0(5'd20, 32'hFFFF_FFFF);
    rd(5'd20);
    total++;
    if (bus.DOut !== 32'h0) begin
      bad++;
      $display("FAIL ill_a20 got=%h exp=0", bus.DOut);
    end
    rd(5'd12);
    total++;
    if (bus.DOut !== 32'h0000_0401) begin
      bad++;
      $display("FAIL ill_sr got=%h exp=%h", bus.DOut, 32'h401);
    end
  endtask

  task automatic test_wrap;
    mtc0(5'd9, 32'hFFFF_FFFF);
    rd(5'd9);
    total++;
    if (bus.DOut !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL wrap_max got=%h exp=%h", bus.DOut, 32'hFFFF_FFFF);
    end
    rd(5'd13);
    total++;
    if (bus.DOut !== 32'h0000_8000) begin
      bad++;
      $display("FAIL wrap_ti got=%h exp=%h", bus.DOut, 32'h8000);
    end
    step();
    rd(5'd9);
    total++;
    if (bus.DOut !== 32'h0) begin
      bad++;
      $display("FAIL wrap_zero got=%h exp=0", bus.DOut);
    end
  endtask

  task automatic test_mid_reset;
    mtc0(5'd12, 32'h0000_8401);
    bus.HWInt = 6'b000001;
    step();
    total++;
    if (bus.IntReq !== 1'b1) begin
      bad++;
      $display("FAIL mid_pre got=%b exp=1", bus.IntReq);
    end
    #2;
    reset = 1'b0;
    #1;
    rd(5'd13);
    total++;
    if (bus.DOut !== 32'h0 || bus.IntReq !== 1'b0 || bus.EPC !== 32'h0) begin
      bad++;
      $display("FAIL mid_reset got=%h/%b/%h exp=0/0/0",
               bus.DOut, bus.IntReq, bus.EPC);
    end
    bus.HWInt = 6'b0;
    @(negedge clk);
    reset = 1'b1;
    step();
  endtask

  initial begin
    total = 0;
    bad = 0;
    bus.A1 = '0;
    bus.A2 = '0;
    bus.DIn = '0;
    bus.PC = '0;
    bus.HWInt = '0;
    bus.We = 1'b0;
    bus.EPCWr = 1'b0;
    bus.EXLSet = 1'b0;
    bus.EXLClr = 1'b0;
    test_reset();
    test_device_int();
    test_masking();
    test_timer();
    test_collisions();
    test_illegal();
    test_wrap();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cp0_unit.md
# cp0_unit

Coprocessor-0 block of the multicycle MIPS microsystem. It holds the SR, Cause, EPC, PRId and Count/Compare registers, and raises the interrupt request that the controller samples at the end of each instruction. It consumes the controller's Wen (MTC0), EPCWr, EXLSet and EXLClr strobes. It serves MFC0 reads to the register-file write-back mux (WDSel = 110) and supplies EPC to the next-PC logic (NPCOp = 100).

## Interface
- PRID, 32'h0000_4D50, constant value returned for register 15.
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- A1  input  5  read select (instruction rd field for MFC0).
- A2  input  5  write select (instruction rd field for MTC0).
- DIn  input  32  MTC0 write data (GPR[rt]).
- PC  input  32  resume address captured into EPC on EPCWr.
- HWInt  input  6  external device interrupt lines, level-sensitive, active-high.
- We  input  1  MTC0 write enable (controller Wen).
- EPCWr  input  1  capture PC into EPC.
- EXLSet  input  1  enter exception level.
- EXLClr  input  1  leave exception level (ERET).
- IntReq  output  1  interrupt request to the controller.
- EPC  output  32  current EPC register.
- DOut  output  32  MFC0 read data.

## Operation
- Register map:
  - 9 = Count.
  - 11 = Compare.
  - 12 = SR: IM[15:10], EXL bit 1, IE bit 0; all other bits read 0.
  - 13 = Cause: IP[15:10], ExcCode[6:2] fixed 0; others read 0.
  - 14 = EPC.
  - 15 = PRId.
  - Any other address reads 0 and ignores writes.
- DOut: combinational mux on A1.
- MTC0 (We=1) writes DIn to A2 if writable:
  - SR: writes only IM/EXL/IE.
  - EPC: writes {DIn[31:2],2'b00}.
  - Count: writes full 32 bits.
  - Compare: writes full 32 bits and also clears the timer-pending flag TI.
  - Cause and PRId: writes ignored.
- Count increments by 1 every cycle, wrapping 32'hFFFF_FFFF -> 0.
- When the post-update Count equals Compare, TI is set (sticky). Only a Compare write clears TI.
- Cause.IP is registered every cycle: IP[15:11] <= HWInt[5:1]; IP[10] <= HWInt[0].
- Cause.IP[15] is ORed with TI.
- IntReq = |(IP & IM) & IE & ~EXL; combinational from registers only.
- EPCWr: EPC <= {PC[31:2],2'b00}.
- EXLSet: EXL <= 1.
- EXLClr: EXL <= 0.
- Priorities in the same cycle:
  - EXLSet over EXLClr over an MTC0 SR write for the EXL bit; SR IM/IE still take DIn.
  - EPCWr over an MTC0 EPC write.
  - MTC0 Count write over increment.
  - A Compare write clears TI even if the match occurs that cycle.

## Timing
- Reset values, applied asynchronously while reset=0:
  - SR = 0 (interrupts disabled).
  - Cause.IP = 0.
  - EPC = 0.
  - Count = 0.
  - Compare = 32'hFFFF_FFFF.
  - TI = 0.
  - IntReq = 0.
  - EPC output = 0.
  - DOut follows A1 (PRId readable during reset).
- Register writes become visible on DOut/EPC one cycle after the strobe edge.
- HWInt -> IntReq latency: 1 cycle (IP register). Deassertion also takes 1 cycle.
- Count/Compare match -> IntReq: TI is set at the edge where Count becomes equal, so IntReq rises the same cycle that Count reads equal to Compare.
- After EXLSet, IntReq is 0 from the next cycle, so the controller never re-enters its interrupt state back-to-back.
- After EXLClr, a still-pending unmasked interrupt raises IntReq the next cycle.
- A mid-operation reset discards any pending TI and IP immediately.
- No handshake: strobes are single-cycle pulses from the controller and are acted on at every edge where high.

## Test plan
- Reset check: reset=0 -> EPC=0, IntReq=0; DOut is 0 for A1=12 and 32'h0000_4D50 for A1=15. Release reset; after 3 cycles A1=9 reads 3.
- Device interrupt: MTC0 SR=32'h0000_0401, then HWInt=6'b000001 -> IntReq=1 one cycle later. Pulse EPCWr+EXLSet with PC=32'h0000_3008 -> EPC=32'h0000_3008, SR reads 32'h0000_0403, IntReq=0. Pulse EXLClr with HWInt still high -> IntReq=1 next cycle.
- Masking: SR=32'h0000_0001 (IM=0) with HWInt=6'b111111 -> IntReq stays 0 and Cause reads 32'h0000_FC00.
- Timer: SR=32'h0000_8001, Count=0, Compare=10 -> IntReq rises when Count reads 10 and holds after Count passes 10. MTC0 Compare=100 -> IntReq drops next cycle.
- Collisions:
  - We to EPC (DIn=32'h1234) together with EPCWr, PC=32'h3000 -> EPC=32'h3000.
  - EXLSet with EXLClr -> EXL=1.
  - Count write of 32'hFFFF_FFFF -> reads 0 one cycle later (wrap).
- Illegal access: MTC0 A2=13 or 15 or 20 -> Cause/PRId unchanged; A1=20 reads 0.
